// File: rtl/cordic_pkg.sv
// cordic_pkg: shared types and constant generators for the CORDIC sin/cos engine.
// All constants are built from high-precision master values and rounded to
// nearest at the requested number of fraction bits.
package cordic_pkg;

  typedef enum logic [1:0] {IDLE, REDUCE, ROTATE, DONE} state_t;

  // pi with 60 fraction bits, 1/K with 31 fraction bits
  localparam logic [63:0] PI_M60    = 64'h3243F6A8885A308D;
  localparam logic [63:0] K_INV_M31 = 64'd1304065748;

  // Re-scale an unsigned master value from mfrac to frac fraction bits,
  // rounding to nearest when bits are dropped.
  function automatic logic [63:0] rshift_rnd(input logic [63:0] m, input int mfrac,
                                             input int frac);
    if (frac >= mfrac) return m << (frac - mfrac);
    return (m + (64'd1 << (mfrac - frac - 1))) >> (mfrac - frac);
  endfunction

  // atan(2^-i) with 31 fraction bits; beyond i=10 it equals 2^-i to well below 1 LSB.
  function automatic logic [63:0] atan_master(input int i);
    case (i)
      0:  return 64'd1686629713;
      1:  return 64'd995675659;
      2:  return 64'd526087673;
      3:  return 64'd267050317;
      4:  return 64'd134043374;
      5:  return 64'd67087031;
      6:  return 64'd33551702;
      7:  return 64'd16776875;
      8:  return 64'd8388565;
      9:  return 64'd4194299;
      10: return 64'd2097151;
      default: begin
        if (i >= 11 && i <= 31) return 64'd1 << (31 - i);
        return 64'd0;
      end
    endcase
  endfunction

  function automatic logic [63:0] atan_tbl(input int i, input int frac);
    return rshift_rnd(atan_master(i), 31, frac);
  endfunction

  function automatic logic [63:0] k_inv(input int frac);
    return rshift_rnd(K_INV_M31, 31, frac);
  endfunction

  function automatic logic [63:0] pi_fx(input int frac);
    return rshift_rnd(PI_M60, 60, frac);
  endfunction

  // Doubling/halving pi is done by re-labelling the master's fraction point.
  function automatic logic [63:0] two_pi_fx(input int frac);
    return rshift_rnd(PI_M60, 59, frac);
  endfunction

  function automatic logic [63:0] half_pi_fx(input int frac);
    return rshift_rnd(PI_M60, 61, frac);
  endfunction

  function automatic logic [63:0] three_half_pi_fx(input int frac);
    return rshift_rnd(PI_M60 * 64'd3, 61, frac);
  endfunction

endpackage

// File: rtl/cordic_angle_fold.sv
// cordic_angle_fold: folds an angle in [0, 2pi) into the first quadrant.
//   a_i    : angle, signed <int,FRAC>, must already lie in [0, 2pi)
//   z_o    : folded angle in [0, pi/2]
//   quad_o : source quadrant 0..3 (lower quadrant edge inclusive)
module cordic_angle_fold
  import cordic_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FRAC  = 15
) (
  input  logic signed [WIDTH-1:0] a_i,
  output logic signed [WIDTH-1:0] z_o,
  output logic        [1:0]       quad_o
);

  localparam logic signed [WIDTH-1:0] HALF_PI       = WIDTH'(half_pi_fx(FRAC));
  localparam logic signed [WIDTH-1:0] PI            = WIDTH'(pi_fx(FRAC));
  localparam logic signed [WIDTH-1:0] THREE_HALF_PI = WIDTH'(three_half_pi_fx(FRAC));
  localparam logic signed [WIDTH-1:0] TWO_PI        = WIDTH'(two_pi_fx(FRAC));

  always_comb begin
    z_o    = a_i;
    quad_o = 2'd0;
    if (a_i >= THREE_HALF_PI) begin
      z_o    = TWO_PI - a_i;
      quad_o = 2'd3;
    end else if (a_i >= PI) begin
      z_o    = a_i - PI;
      quad_o = 2'd2;
    end else if (a_i >= HALF_PI) begin
      z_o    = PI - a_i;
      quad_o = 2'd1;
    end
  end

endmodule

// File: rtl/cordic_sincos.sv
// cordic_sincos: iterative CORDIC returning sin and cos of one signed angle.
//   clk, rst : clock and synchronous active-high reset
//   start    : request, taken only while ready is high
//   angle    : radians, signed <int,FRAC>, any value (range-reduced here)
//   ready    : high while idle
//   sin_out  : signed <int,FRAC>, held until the next result
//   cos_out  : signed <int,FRAC>, held until the next result
//   valid    : one-cycle pulse on the cycle sin_out/cos_out update
// Large angles are reduced by one 2pi step per cycle, so latency grows with
// |angle|/2pi; callers with huge angles are expected to pre-reduce.
module cordic_sincos
  import cordic_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FRAC  = 15,
  parameter int ITERS = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] angle,
  output logic                    ready,
  output logic signed [WIDTH-1:0] sin_out,
  output logic signed [WIDTH-1:0] cos_out,
  output logic                    valid
);

  localparam int IW = $clog2(ITERS + 1);
  localparam logic [IW-1:0]           LAST   = IW'(ITERS - 1);
  localparam logic signed [WIDTH-1:0] TWO_PI = WIDTH'(two_pi_fx(FRAC));
  localparam logic signed [WIDTH-1:0] K_INV  = WIDTH'(k_inv(FRAC));

  state_t                   state_q;
  logic signed [WIDTH-1:0]  a_q, x_q, y_q, z_q;
  logic        [IW-1:0]     i_q;
  logic        [1:0]        quad_q;
  logic signed [WIDTH-1:0]  sin_q, cos_q;
  logic                     valid_q, ready_q;

  logic signed [WIDTH-1:0]  fold_z;
  logic        [1:0]        fold_quad;
  logic signed [WIDTH-1:0]  atan_cur, x_sh, y_sh;
  logic signed [WIDTH-1:0]  x_d, y_d, z_d, sin_d, cos_d;

  cordic_angle_fold #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_fold (
    .a_i    (a_q),
    .z_o    (fold_z),
    .quad_o (fold_quad)
  );

  // One micro-rotation; both updates read the pre-rotation x and y.
  always_comb begin
    atan_cur = WIDTH'(atan_tbl(int'(i_q), FRAC));
    x_sh     = x_q >>> i_q;
    y_sh     = y_q >>> i_q;
    if (!z_q[WIDTH-1]) begin
      x_d = x_q - y_sh;
      y_d = y_q + x_sh;
      z_d = z_q - atan_cur;
    end else begin
      x_d = x_q + y_sh;
      y_d = y_q - x_sh;
      z_d = z_q + atan_cur;
    end
    // sin negative in Q2/Q3, cos negative in Q1/Q2
    sin_d = quad_q[1] ? -y_q : y_q;
    cos_d = (quad_q[1] ^ quad_q[0]) ? -x_q : x_q;
  end

  always_ff @(posedge clk) begin
    valid_q <= 1'b0;
    if (rst) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      sin_q   <= '0;
      cos_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= angle;
            ready_q <= 1'b0;
            state_q <= REDUCE;
          end
        end
        REDUCE: begin
          if (a_q[WIDTH-1]) begin
            a_q <= a_q + TWO_PI;
          end else if (a_q >= TWO_PI) begin
            a_q <= a_q - TWO_PI;
          end else begin
            z_q     <= fold_z;
            quad_q  <= fold_quad;
            x_q     <= K_INV;
            y_q     <= '0;
            i_q     <= '0;
            state_q <= ROTATE;
          end
        end
        ROTATE: begin
          x_q <= x_d;
          y_q <= y_d;
          z_q <= z_d;
          i_q <= i_q + 1'b1;
          if (i_q == LAST) state_q <= DONE;
        end
        DONE: begin
          sin_q   <= sin_d;
          cos_q   <= cos_d;
          valid_q <= 1'b1;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready   = ready_q;
  assign valid   = valid_q;
  assign sin_out = sin_q;
  assign cos_out = cos_q;

endmodule

// File: tb/tb_cordic_sincos.sv
// Scoreboard bench for cordic_sincos at default parameters: the driver pushes
// the hand-computed expected sin/cos/latency per accepted request, and a
// monitor pops and compares on every valid pulse.
module tb_cordic_sincos;

  localparam int W = 32;
  localparam int TOL = 8;

  logic                clk, rst, start;
  logic signed [W-1:0] angle;
  logic                ready, valid;
  logic signed [W-1:0] sin_out, cos_out;

  typedef struct {
    int sin_e;
    int cos_e;
    int lat;
    int e0;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   cyc = 0;
  int   n_valid = 0;
  int   checks = 0;
  int   failures = 0;

  cordic_sincos #(.WIDTH(32), .FRAC(15), .ITERS(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .angle   (angle),
    .ready   (ready),
    .sin_out (sin_out),
    .cos_out (cos_out),
    .valid   (valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic void check_eq(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endfunction

  function automatic void check_near(input string name, input longint act, input longint req);
    longint d;
    checks++;
    d = act - req;
    if (d > TOL || d < -TOL) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d+-%0d", name, act, req, TOL);
    end
  endfunction

  // Monitor: every valid pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (valid) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid actual=1 required=0 at cycle %0d", cyc);
      end else begin
        e = exp_q.pop_front();
        check_near("sin", sin_out, e.sin_e);
        check_near("cos", cos_out, e.cos_e);
        check_eq("latency", cyc - e.e0, e.lat);
      end
    end
  end

  // Called at #1 after a rising edge; returns at #1 after the accepting edge.
  task automatic issue(input int ang, input int sin_e, input int cos_e, input int lat);
    int g;
    g = 0;
    while (!ready && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    if (!ready) begin
      checks++;
      failures++;
      $display("FAIL ready_wait actual=0 required=1");
    end
    start = 1'b1;
    angle = ang;
    @(posedge clk); #1;
    start = 1'b0;
    exp_q.push_back('{sin_e, cos_e, lat, cyc});
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 300) begin
      @(posedge clk); #1;
      g++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0 outstanding", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run(input int ang, input int sin_e, input int cos_e, input int lat);
    issue(ang, sin_e, cos_e, lat);
    drain();
  endtask

  initial begin
    int v0;
    int g;
    rst   = 1'b1;
    start = 1'b0;
    angle = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", ready, 1);
    check_eq("rst_valid", valid, 0);
    check_eq("rst_sin", sin_out, 0);
    check_eq("rst_cos", cos_out, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // In-range angles across all quadrants and the fold boundaries
    run(0,       0,      32768, 18);
    run(51471,   32768,  0,     18);
    run(17157,   16384,  28378, 18);
    run(171570, -28378,  16384, 18);
    run(85786,   16384, -28378, 18);
    run(120101, -16384, -28378, 18);
    run(102944,  0,     -32768, 18);

    // Range reduction: exactly 2pi, negative, and two extra turns
    run(205887,          0,      32768, 19);
    run(-17157,         -16384,  28378, 19);
    run(17157 + 2*205887, 16384, 28378, 20);

    // start pulsed during rotation is ignored
    v0 = n_valid;
    issue(17157, 16384, 28378, 18);
    repeat (6) @(posedge clk);
    #1;
    check_eq("busy_ready", ready, 0);
    start = 1'b1;
    angle = 51471;
    @(posedge clk); #1;
    start = 1'b0;
    drain();
    repeat (25) @(posedge clk);
    #1;
    check_eq("ignored_start_valids", n_valid - v0, 1);

    // Reset in the middle of ROTATE discards the result
    issue(171570, -28378, 16384, 18);
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("midrst_sin", sin_out, 0);
    check_eq("midrst_cos", cos_out, 0);
    check_eq("midrst_ready", ready, 1);
    check_eq("midrst_valid", valid, 0);
    v0 = n_valid;
    repeat (30) @(posedge clk);
    #1;
    check_eq("midrst_no_valid", n_valid - v0, 0);

    // start held high across valid: next run begins with no idle gap
    start = 1'b1;
    angle = 17157;
    @(posedge clk); #1;
    exp_q.push_back('{16384, 28378, 18, cyc});
    g = 0;
    while (!valid && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    check_eq("b2b_valid_seen", valid, 1);
    check_eq("b2b_ready_on_valid", ready, 1);
    angle = 171570;
    @(posedge clk); #1;
    exp_q.push_back('{-28378, 16384, 18, cyc});
    check_eq("b2b_ready_after", ready, 0);
    start = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
